cpr_rc_ring_counter: RTL and testbench

//  Measurement stage directly downstream of the CPR soft RC ring oscillator.
//  - Drives the ring power-down input (PD_RC) and consumes its output (PDRCOut).
//  - Counts ring rising edges over a programmable window of clk_i cycles.
//  - Returns the count to the power-management controller over a valid/ready handshake.
//  - The count is the speed figure of the critical-path replica.

---
 rtl/cpr_rc_ring_counter_pkg.sv | 21 ++
 rtl/cpr_rc_ring_counter_sync_edge.sv | 27 ++
 rtl/cpr_rc_ring_counter.sv | 150 +++++++++++++++
 tb/tb_cpr_rc_ring_counter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpr_rc_ring_counter_pkg.sv
// Shared types and default widths for the CPR ring-oscillator measurement stage.
package cpr_pkg;

  localparam int CPR_CNT_W         = 16;
  localparam int CPR_WIN_W         = 16;
  localparam int CPR_SETTLE_CYCLES = 8;
  localparam int CPR_SYNC_STAGES   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARMUP  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } cpr_state_e;

  // Width needed to hold a down-counter load value n (at least one bit).
  function automatic int cnt_bits(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cpr_rc_ring_counter_sync_edge.sv
// Synchroniser for the asynchronous ring output plus a one-cycle rising-edge pulse.
module cpr_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_o
);

  // CDC: the first stage samples an asynchronous signal and may go metastable.
  (* async_reg = "true" *) logic [STAGES-1:0] sync_q;
  logic sync_q_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      sync_q_d <= 1'b0;
    end else begin
      sync_q   <= {sync_q[STAGES-2:0], async_i};
      sync_q_d <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~sync_q_d;

endmodule

// File: rtl/cpr_rc_ring_counter.sv
// CPR ring-oscillator edge counter: warm-up, windowed count, synchroniser drain, result hand-off.
// Optional slow-threshold comparator is built when CPR_THR_CMP_EN is defined.
module cpr_rc_ring_counter
  import cpr_pkg::*;
#(
  parameter int WIN_W         = CPR_WIN_W,
  parameter int CNT_W         = CPR_CNT_W,
  parameter int SETTLE_CYCLES = CPR_SETTLE_CYCLES,
  parameter int SYNC_STAGES   = CPR_SYNC_STAGES
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIN_W-1:0] window_i,
  input  logic             rc_osc_i,
  output logic             pd_rc_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             cnt_valid_o,
  input  logic             cnt_ready_i,
  output logic             overflow_o,
`ifdef CPR_THR_CMP_EN
  input  logic [CNT_W-1:0] thr_i,
  output logic             slow_o,
`endif
  output cpr_state_e       state_o
);

  localparam int ST_W = cnt_bits(SETTLE_CYCLES - 1);
  localparam int DR_W = cnt_bits(SYNC_STAGES);
  localparam logic [ST_W-1:0]  SETTLE_LOAD = ST_W'(SETTLE_CYCLES - 1);
  localparam logic [DR_W-1:0]  DRAIN_LOAD  = DR_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  cpr_state_e       state_q;
  logic [WIN_W-1:0] win_q;
  logic [ST_W-1:0]  settle_q;
  logic [DR_W-1:0]  drain_q;
  logic             draining_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             pd_q;
  logic             rise;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_nxt;
`ifdef CPR_THR_CMP_EN
  logic [CNT_W-1:0] thr_q;
  logic             slow_q;
`endif

  cpr_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_edge (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .async_i (rc_osc_i),
    .rise_o  (rise)
  );

  // Pulses are counted through the whole MEASURE state, including the drain
  // tail, so edges still travelling through the synchroniser are not lost.
  always_comb begin
    cnt_nxt = cnt_q;
    ovf_nxt = ovf_q;
    if (state_q == MEASURE && rise) begin
      if (cnt_q == CNT_MAX) ovf_nxt = 1'b1;
      else                  cnt_nxt = cnt_q + 1'b1;
    end
  end

  // Result handshake: cnt_valid_o is high for the whole DONE state and the
  // result fields are frozen; the transfer happens on a clock edge where
  // cnt_valid_o & cnt_ready_i, after which the block returns to IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      win_q      <= '0;
      settle_q   <= '0;
      drain_q    <= '0;
      draining_q <= 1'b0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      pd_q       <= 1'b1;
`ifdef CPR_THR_CMP_EN
      thr_q      <= '0;
      slow_q     <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_nxt;
      ovf_q <= ovf_nxt;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            win_q      <= window_i;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            draining_q <= 1'b0;
            settle_q   <= SETTLE_LOAD;
`ifdef CPR_THR_CMP_EN
            thr_q      <= thr_i;
`endif
            if (window_i == '0) begin
              state_q <= DONE;
`ifdef CPR_THR_CMP_EN
              slow_q  <= (thr_i != '0);
`endif
            end else begin
              state_q <= WARMUP;
              pd_q    <= 1'b0;
            end
          end
        end
        WARMUP: begin
          if (settle_q == '0) state_q <= MEASURE;
          else                settle_q <= settle_q - 1'b1;
        end
        MEASURE: begin
          if (!draining_q) begin
            win_q <= win_q - 1'b1;
            if (win_q == WIN_W'(1)) begin
              draining_q <= 1'b1;
              drain_q    <= DRAIN_LOAD;
              pd_q       <= 1'b1;
            end
          end else if (drain_q == '0) begin
            state_q <= DONE;
`ifdef CPR_THR_CMP_EN
            slow_q  <= ~ovf_nxt & (cnt_nxt < thr_q);
`endif
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end
        DONE: begin
          if (cnt_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pd_rc_o     = pd_q;
  assign busy_o      = (state_q != IDLE);
  assign cnt_o       = cnt_q;
  assign cnt_valid_o = (state_q == DONE);
  assign overflow_o  = ovf_q;
  assign state_o     = state_q;
`ifdef CPR_THR_CMP_EN
  assign slow_o      = slow_q;
`endif

endmodule

// File: tb/tb_cpr_rc_ring_counter.sv
// Bench for cpr_rc_ring_counter; one time unit = 0.5 ns (clk_i = 10 units, ring default 100 units).
module tb_cpr_rc_ring_counter;
  import cpr_pkg::*;

  localparam int CLK_P   = 10;
  localparam int WIN_W   = 16;
  localparam int CNT_W   = 16;
  localparam int CNT_W_S = 4;
  localparam int SETTLE  = 8;
  localparam int SYNC    = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance (CNT_W=16)
  logic             start  = 1'b0;
  logic [WIN_W-1:0] window = '0;
  logic             rc     = 1'b0;
  logic             ready  = 1'b0;
  logic             pd, busy, valid, ovf;
  logic [CNT_W-1:0] cnt;
  cpr_state_e       st;
  // small instance (CNT_W=4) for saturation
  logic               start_s  = 1'b0;
  logic [WIN_W-1:0]   window_s = '0;
  logic               rc_s     = 1'b0;
  logic               ready_s  = 1'b0;
  logic               pd_s, busy_s, valid_s, ovf_s;
  logic [CNT_W_S-1:0] cnt_s;
  cpr_state_e         st_s;
`ifdef CPR_THR_CMP_EN
  logic [CNT_W-1:0]   thr   = '0;
  logic [CNT_W_S-1:0] thr_s = '0;
  logic               slow, slow_s;
`endif

  cpr_rc_ring_counter #(.WIN_W(WIN_W), .CNT_W(CNT_W), .SETTLE_CYCLES(SETTLE), .SYNC_STAGES(SYNC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .window_i(window), .rc_osc_i(rc),
    .pd_rc_o(pd), .busy_o(busy), .cnt_o(cnt), .cnt_valid_o(valid), .cnt_ready_i(ready),
    .overflow_o(ovf),
`ifdef CPR_THR_CMP_EN
    .thr_i(thr), .slow_o(slow),
`endif
    .state_o(st)
  );

  cpr_rc_ring_counter #(.WIN_W(WIN_W), .CNT_W(CNT_W_S), .SETTLE_CYCLES(SETTLE), .SYNC_STAGES(SYNC)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_s), .window_i(window_s), .rc_osc_i(rc_s),
    .pd_rc_o(pd_s), .busy_o(busy_s), .cnt_o(cnt_s), .cnt_valid_o(valid_s), .cnt_ready_i(ready_s),
    .overflow_o(ovf_s),
`ifdef CPR_THR_CMP_EN
    .thr_i(thr_s), .slow_o(slow_s),
`endif
    .state_o(st_s)
  );

  // ---------------- ring oscillator models ----------------
  int unsigned ring_p = 100;
  longint      edge_t[$];
  bit          pd_low_seen = 1'b0;

  always begin
    wait (pd == 1'b0);
    #1;
    while (pd == 1'b0) begin
      #(ring_p / 2);
      if (pd == 1'b0) begin
        rc = 1'b1;
        edge_t.push_back($time);
      end
      #(ring_p / 2);
      rc = 1'b0;
    end
  end

  always begin
    wait (pd_s == 1'b0);
    #1;
    while (pd_s == 1'b0) begin
      #50;
      if (pd_s == 1'b0) rc_s = 1'b1;
      #50;
      rc_s = 1'b0;
    end
  end

  always @(negedge clk) if (pd === 1'b0) pd_low_seen = 1'b1;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  function automatic void chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void chk_near(input string name, input longint act, input longint exp, input longint tol);
    total++;
    if (act < exp - tol || act > exp + tol) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endfunction

  // Edges the ring produced inside the nominal counting window [t0+SETTLE, t0+SETTLE+w] cycles.
  function automatic int unsigned model_count(input longint t0, input int unsigned w);
    longint lo, hi;
    int unsigned n;
    lo = t0 + longint'(SETTLE * CLK_P);
    hi = t0 + longint'((SETTLE + w) * CLK_P);
    n  = 0;
    foreach (edge_t[i]) if (edge_t[i] > lo && edge_t[i] <= hi) n++;
    return n;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_meas(input string tag, input int unsigned w, input int unsigned p,
                          input int unsigned hold, input int unsigned lat_exp);
    longint      t0;
    int unsigned n;
    int          unstable;
    logic [CNT_W-1:0] snap;
    logic [31:0] e;
    ring_p = p;
    edge_t.delete();
    pd_low_seen = 1'b0;
    @(negedge clk);
    start  = 1'b1;
    window = WIN_W'(w);
`ifdef CPR_THR_CMP_EN
    thr = (w == 1000 && p == 100) ? CNT_W'(101) : '0;
`endif
    @(posedge clk);
    t0 = $time;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (valid !== 1'b1 && n < w + 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, lat_exp);
    chk({tag, "_pd_done"}, pd, 1);
    chk({tag, "_busy_done"}, busy, 1);
    exp_q.push_back(model_count(t0, w));
    e = exp_q.pop_front();
    chk_near({tag, "_cnt"}, cnt, e, 1);
    chk({tag, "_ovf"}, ovf, 0);
    if (w == 0) begin
      chk({tag, "_cnt_zero"}, cnt, 0);
      chk({tag, "_pd_never_low"}, pd_low_seen, 0);
    end
    if (w == 1000 && p == 100) chk_near({tag, "_nominal"}, cnt, 100, 1);
`ifdef CPR_THR_CMP_EN
    chk({tag, "_slow"}, slow, (w == 1000 && p == 100) ? 1 : 0);
`endif
    snap = cnt;
    unstable = 0;
    for (int i = 0; i < int'(hold); i++) begin
      start = (hold >= 50 && (i % 7) == 3);
      @(negedge clk);
      if (cnt !== snap || valid !== 1'b1 || pd !== 1'b1 || st !== DONE) unstable++;
    end
    start = 1'b0;
    if (hold > 0) chk({tag, "_hold_stable"}, unstable, 0);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk({tag, "_valid_drop"}, valid, 0);
    chk({tag, "_idle_after"}, longint'(st), longint'(IDLE));
    @(negedge clk);
    chk({tag, "_no_queued_start"}, busy, 0);
  endtask

  task automatic run_small(input string tag, input int unsigned w);
    int unsigned n, model;
    model = w * CLK_P / 100;
    @(negedge clk);
    start_s  = 1'b1;
    window_s = WIN_W'(w);
    @(negedge clk);
    start_s = 1'b0;
    n = 1;
    while (valid_s !== 1'b1 && n < w + 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, valid_s, 1);
    if (model > 15) begin
      chk({tag, "_cnt_sat"}, cnt_s, 15);
      chk({tag, "_ovf"}, ovf_s, 1);
    end else begin
      chk_near({tag, "_cnt"}, cnt_s, model, 1);
      chk({tag, "_ovf_clear"}, ovf_s, 0);
    end
    ready_s = 1'b1;
    @(negedge clk);
    ready_s = 1'b0;
    chk({tag, "_valid_drop"}, valid_s, 0);
  endtask

  // ---------------- test sequence ----------------
  typedef struct {
    int unsigned win;
    int unsigned period;
    int unsigned hold;
    int unsigned lat;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int unsigned w, p;
    vecs[0] = '{win: 1000, period: 100, hold: 3,  lat: 1 + SETTLE + 1000 + SYNC + 1};
    vecs[1] = '{win: 0,    period: 100, hold: 2,  lat: 1};
    vecs[2] = '{win: 1,    period: 40,  hold: 0,  lat: 1 + SETTLE + 1 + SYNC + 1};
    vecs[3] = '{win: 37,   period: 60,  hold: 50, lat: 1 + SETTLE + 37 + SYNC + 1};

    // reset state
    #12;
    chk("rst_pd", pd, 1);
    chk("rst_valid", valid, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_idle", longint'(st), longint'(IDLE));
    chk("post_rst_pd", pd, 1);

    foreach (vecs[i]) run_meas($sformatf("vec%0d", i), vecs[i].win, vecs[i].period, vecs[i].hold, vecs[i].lat);

    for (int i = 0; i < 6; i++) begin
      w = $urandom_range(1, 300);
      p = 10 * $urandom_range(4, 16);
      run_meas($sformatf("rnd%0d", i), w, p, $urandom_range(0, 5), 1 + SETTLE + w + SYNC + 1);
    end

    run_small("sat400", 400);
    run_small("sat_clear", 100);

    // reset in the middle of a measurement
    ring_p = 100;
    @(negedge clk);
    start  = 1'b1;
    window = WIN_W'(1000);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 60 && st !== MEASURE; i++) @(negedge clk);
    chk("mid_in_measure", longint'(st), longint'(MEASURE));
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_pd", pd, 1);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_rst_stay_idle", valid, 0);
    chk("mid_rst_pd_after", pd, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
